// File: rtl/conv_pool_stage.sv
`default_nettype none
// ============================================================================
// Module   : conv_pool_stage
// Purpose  : Bias add with Q8.24 saturation, optional ReLU, then 2x2/stride-2
//            max pooling over a raster stream of IMG_W-wide conv results.
//            Optional ReLU is enabled by defining CONV_POOL_RELU_EN.
// Revision : 1.0 - initial release
// ============================================================================
module conv_pool_stage #(
  parameter int IMG_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataIn,
  input  logic        dataValid,
  input  logic [31:0] bias,
  input  logic        biasLoad,
  output logic [31:0] dataOut,
  output logic        outValid
);

  localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int HALF  = IMG_W / 2;
  localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [31:0]      C_SAT_POS  = 32'h7FFF_FFFF;
  localparam logic [31:0]      C_SAT_NEG  = 32'h8000_0000;

  function automatic logic [31:0] smax(input logic [31:0] a, input logic [31:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // State registers and their next-state values
  logic [31:0]      bias_q,     bias_d;
  logic [COL_W-1:0] col_q,      col_d;
  logic             row_odd_q,  row_odd_d;
  logic [31:0]      pair_q,     pair_d;
  logic [31:0]      data_out_q, data_out_d;
  logic             out_vld_q,  out_vld_d;
  logic [31:0]      row_buf_q [HALF];

  // Datapath wires
  logic [32:0]      w_sum;
  logic [31:0]      w_sat;
  logic [31:0]      w_relu;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_buf_rd;
  logic [31:0]      w_pair_max;
  logic             w_buf_we;

  // 33-bit signed add: disagreement of the top two bits means overflow.
  assign w_sum = {dataIn[31], dataIn} + {bias_q[31], bias_q};

  always_comb begin
    w_sat = w_sum[31:0];
    if (w_sum[32] != w_sum[31]) begin
      w_sat = w_sum[32] ? C_SAT_NEG : C_SAT_POS;
    end
  end

`ifdef CONV_POOL_RELU_EN
  assign w_relu = w_sat[31] ? 32'h0 : w_sat;
`else
  assign w_relu = w_sat;
`endif

  assign w_idx      = IDX_W'(col_q >> 1);
  assign w_buf_rd   = row_buf_q[w_idx];
  assign w_pair_max = smax(pair_q, w_relu);

  always_comb begin
    bias_d     = bias_q;
    col_d      = col_q;
    row_odd_d  = row_odd_q;
    pair_d     = pair_q;
    data_out_d = data_out_q;
    out_vld_d  = 1'b0;
    w_buf_we   = 1'b0;

    // Sample in flight this edge still sees the old bias.
    if (biasLoad) begin
      bias_d = bias;
    end

    if (dataValid) begin
      if (col_q == C_COL_LAST) begin
        col_d     = '0;
        row_odd_d = ~row_odd_q;
      end else begin
        col_d = col_q + COL_W'(1);
      end

      if (!col_q[0]) begin
        pair_d = w_relu;
      end else if (!row_odd_q) begin
        w_buf_we = 1'b1;
      end else begin
        data_out_d = smax(w_buf_rd, w_pair_max);
        out_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bias_q     <= '0;
      col_q      <= '0;
      row_odd_q  <= 1'b0;
      pair_q     <= '0;
      data_out_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      bias_q     <= bias_d;
      col_q      <= col_d;
      row_odd_q  <= row_odd_d;
      pair_q     <= pair_d;
      data_out_q <= data_out_d;
      out_vld_q  <= out_vld_d;
    end
  end

  // Row buffer needs no reset: every entry is written on the even row first.
  always_ff @(posedge clk) begin
    if (!reset && w_buf_we) begin
      row_buf_q[w_idx] <= w_pair_max;
    end
  end

  assign dataOut  = data_out_q;
  assign outValid = out_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_pool_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_pool_stage
// Purpose  : Scoreboard bench for conv_pool_stage with IMG_W=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_pool_stage;

  typedef struct {
    logic [31:0] val;
    int          cyc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataIn;
  logic        dataValid;
  logic [31:0] bias;
  logic        biasLoad;
  logic [31:0] dataOut;
  logic        outValid;

  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;
  exp_t exp_q[$];

  logic [31:0] basic_v [8] = '{32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000,
                               32'h0080_0000, 32'h0280_0000, 32'hFF00_0000, 32'h0500_0000};

  conv_pool_stage #(.IMG_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .dataIn   (dataIn),
    .dataValid(dataValid),
    .bias     (bias),
    .biasLoad (biasLoad),
    .dataOut  (dataOut),
    .outValid (outValid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every outValid pulse must match the head of the queue in value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL %s missing pulse: expected %h at cycle %0d", e.name, e.val, e.cyc);
    end
    if (outValid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse cycle %0d dataOut=%h required no pulse", cyc, dataOut);
      end else begin
        e = exp_q.pop_front();
        if (dataOut !== e.val || cyc != e.cyc) begin
          n_err++;
          $display("FAIL %s got %h at cycle %0d, required %h at cycle %0d",
                   e.name, dataOut, cyc, e.val, e.cyc);
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit emit, input logic [31:0] ev, input string nm);
    dataIn    = d;
    dataValid = 1'b1;
    @(posedge clk);
    #1;
    dataValid = 1'b0;
    biasLoad  = 1'b0;
    if (emit) exp_q.push_back('{ev, cyc, nm});
  endtask

  task automatic load_bias(input logic [31:0] b);
    bias     = b;
    biasLoad = 1'b1;
    @(posedge clk);
    #1;
    biasLoad = 1'b0;
  endtask

  // Two rows of IMG_W=4 samples; outputs expected after the 6th and 8th inputs.
  task automatic run_frame(input logic [31:0] v [8], input logic [31:0] e1,
                           input logic [31:0] e2, input int gap, input string nm);
    for (int i = 0; i < 8; i++) begin
      send(v[i], (i == 5) || (i == 7), (i == 5) ? e1 : e2, nm);
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %h required %h", nm, got, want);
    end
  endtask

  initial begin
    logic [31:0] neg_v [8];
    logic [31:0] sat_v [8];
    reset = 1'b1; dataIn = '0; dataValid = 1'b0; bias = '0; biasLoad = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dataOut", dataOut, 32'h0);
    check("reset_outValid", {31'h0, outValid}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_frame(basic_v, 32'h0280_0000, 32'h0500_0000, 0, "basic");

    for (int i = 0; i < 8; i++) neg_v[i] = 32'hFF80_0000;
`ifdef CONV_POOL_RELU_EN
    run_frame(neg_v, 32'h0000_0000, 32'h0000_0000, 0, "relu");
`else
    run_frame(neg_v, 32'hFF80_0000, 32'hFF80_0000, 0, "relu");
`endif

    load_bias(32'h0200_0000);
    for (int i = 0; i < 8; i++) sat_v[i] = 32'h7F00_0000;
    run_frame(sat_v, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, "saturate");

    load_bias(32'hFF00_0000);
    run_frame(basic_v, 32'h0180_0000, 32'h0400_0000, 0, "neg_bias");

    load_bias(32'h0);
    run_frame(basic_v, 32'h0280_0000, 32'h0500_0000, 3, "gaps");

    // Partial row, then reset with a sample presented that must be dropped.
    for (int i = 0; i < 3; i++) send(basic_v[i], 1'b0, 32'h0, "pre_reset");
    reset     = 1'b1;
    dataIn    = 32'h7F00_0000;
    dataValid = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    dataValid = 1'b0;
    check("post_reset_dataOut", dataOut, 32'h0);
    check("post_reset_outValid", {31'h0, outValid}, 32'h0);
    run_frame(basic_v, 32'h0280_0000, 32'h0500_0000, 0, "after_reset");

    // biasLoad on the same edge as the first sample; send clears biasLoad.
    bias     = 32'h0100_0000;
    biasLoad = 1'b1;
    run_frame(basic_v, 32'h0380_0000, 32'h0600_0000, 0, "sim_bias");

    repeat (10) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL %s never seen: required %h at cycle %0d", e.name, e.val, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_pool_stage.md
# conv_pool_stage

Downstream stage of the convolution accelerator. Consumes the stream of Q8.24 dot-product results the accelerator produces, one per 3x3 window in raster order. Applies a per-channel bias and ReLU, then 2x2/stride-2 max pooling across a feature map of `IMG_W` columns. Emits one pooled Q8.24 word per 2x2 block, so the next layer sees one quarter of the data.

## Interface
- `IMG_W`, default 8: conv-output row width in samples; must be even and ≥2.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `dataIn` input, 32 bits: signed Q8.24 conv result (1.0 = 0x01000000).
- `dataValid` input, 1 bit: `dataIn` is consumed on this edge; no backpressure.
- `bias` input, 32 bits: signed Q8.24 bias value.
- `biasLoad` input, 1 bit: captures `bias` into the internal bias register.
- `dataOut` output, 32 bits: pooled Q8.24 result.
- `outValid` output, 1 bit: one-cycle pulse when `dataOut` is new.

## Operation
- Per accepted sample, `s = sat32(dataIn + biasReg)`: signed 33-bit add, clamped to 0x7FFFFFFF / 0x80000000. Then `r = max(s, 0)` (ReLU, see Configuration).
- Counters:
  - `col` runs 0..IMG_W-1 and wraps to 0, toggling `rowOdd`.
  - Both counters advance only on `dataValid`.
  - Frames are continuous; there is no height limit.
- Even `col`: `r` goes into the pair register.
- Odd `col`, `rowOdd`=0: `rowBuf[col>>1] <= max(pair, r)`. `rowBuf` holds IMG_W/2 words.
- Odd `col`, `rowOdd`=1: `dataOut <= max(rowBuf[col>>1], pair, r)` and `outValid <= 1`.
- All max comparisons are signed.
- `biasLoad` is independent of the counters. If `biasLoad` and `dataValid` occur in the same cycle, that sample uses the old `biasReg`; the new value applies from the next sample.

## Timing
- Reset values:
  - `dataOut` = 0, `outValid` = 0.
  - `biasReg` = 0.
  - `col` = 0, `rowOdd` = 0, pair register = 0.
  - `rowBuf` is not cleared; every entry is written on the even row before it is read.
- Latency: `outValid` is high in the cycle after the edge that accepts the odd-row, odd-column sample.
- `dataOut` holds its value until the next emit. `outValid` is high for exactly one cycle per emit.
- Gaps in `dataValid` stall all state. Sustained throughput: one input per cycle, one output per four inputs.
- Reset mid-row or mid-frame: counters return to 0 on that edge and any partial block is discarded. The next sample is row 0, col 0. `reset` overrides a simultaneous `dataValid`, and that sample is dropped.
- `reset` together with `biasLoad`: `biasReg` becomes 0.

## Configuration
- `CONV_POOL_RELU_EN`:
  - Defined: `r = max(s, 0)`.
  - Undefined: `r = s`; pooling runs on raw signed biased values, so negative outputs are possible.
- Saturation, pooling and timing are identical in both builds.

## Test plan
- **Basic pooling.** IMG_W=4, bias 0.
  - Stimulus: row 0 = 1.0, 2.0, 3.0, 4.0; row 1 = 0.5, 2.5, -1.0, 5.0.
  - Response: `outValid` pulses after the 6th input with `dataOut`=0x02800000 (2.5), and after the 8th input with 0x05000000 (5.0). No other pulses.
- **ReLU.** Bias 0; feed eight samples of -0.5 (0xFF800000).
  - With `CONV_POOL_RELU_EN`: two outputs of 0x00000000.
  - Without it: two outputs of 0xFF800000.
- **Bias and saturation.**
  - Load bias 0x02000000 (2.0) and feed 0x7F000000 in every position: outputs are 0x7FFFFFFF.
  - Load bias 0xFF000000 (-1.0) and repeat the basic-pooling stimulus: outputs are 0x01800000 and 0x04000000.
- **Valid gaps.** Basic-pooling stimulus with `dataValid` low for 3 cycles between each sample.
  - Same two outputs with the same values.
  - `outValid` is never high outside the cycle after the 6th and 8th accepted inputs.
- **Reset mid-row.** Feed 3 samples, assert `reset` for one cycle, then apply the basic-pooling stimulus.
  - `dataOut`=0 and `outValid`=0 right after reset.
  - Outputs are then 2.5 and 5.0, exactly as in the basic-pooling test.
- **Simultaneous biasLoad.** Assert `biasLoad` with bias 1.0 on the same edge as the first basic-pooling sample.
  - That sample uses bias 0; later samples use 1.0.
  - Outputs are 0x03800000 and 0x06000000.
